// File: rtl/threshold_sar_ctrl.sv
// threshold_sar_ctrl: MSB-first successive-approximation controller for the threshold sensor.
// Optional feature macro THRESHOLD_SAR_MAJORITY_EN: each bit decision is a 3-sample majority vote.
module threshold_sar_ctrl #(
    parameter int CODE_W        = 3,
    parameter int SETTLE_CYCLES = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              cont,
    input  logic              cmp_in,
    output logic [CODE_W-1:0] code_out,
    output logic              busy,
    output logic [CODE_W-1:0] result,
    output logic              result_valid,
    input  logic              result_ready,
    output logic              overrun
);

    localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [CODE_W-1:0] MSB_CODE = CODE_W'(1) << (CODE_W - 1);
    localparam logic [IDX_W-1:0]  IDX_MSB  = IDX_W'(CODE_W - 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    // The settle window must also flush the comparator synchronizer.
    if (SETTLE_CYCLES < SYNC_STAGES + 1) begin : g_bad_settle
        $error("SETTLE_CYCLES must be at least SYNC_STAGES+1");
    end
    if (CODE_W < 1 || SYNC_STAGES < 1) begin : g_bad_width
        $error("CODE_W and SYNC_STAGES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE
    } state_t;

    state_t            state_reg, state_next;
    logic [CODE_W-1:0] code_reg, code_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [CODE_W-1:0] result_reg, result_next;
    logic              valid_reg, valid_next;
    logic              overrun_reg, overrun_next;
    logic [SYNC_STAGES-1:0] sync_reg, sync_next;
`ifdef THRESHOLD_SAR_MAJORITY_EN
    logic [1:0]        phase_reg, phase_next;
    logic [1:0]        samp_reg, samp_next;
`endif

    logic              cmp_s;
    logic [CODE_W-1:0] trial_code;
    logic              decide;
    logic              bit_value;
    logic              complete;

    assign sync_next[0] = cmp_in;
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
        assign sync_next[gi] = sync_reg[gi-1];
    end
    assign cmp_s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            code_reg    <= '0;
            idx_reg     <= '0;
            cnt_reg     <= '0;
            result_reg  <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
            sync_reg    <= '0;
`ifdef THRESHOLD_SAR_MAJORITY_EN
            phase_reg   <= '0;
            samp_reg    <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            code_reg    <= code_next;
            idx_reg     <= idx_next;
            cnt_reg     <= cnt_next;
            result_reg  <= result_next;
            valid_reg   <= valid_next;
            overrun_reg <= overrun_next;
            sync_reg    <= sync_next;
`ifdef THRESHOLD_SAR_MAJORITY_EN
            phase_reg   <= phase_next;
            samp_reg    <= samp_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        code_next    = code_reg;
        idx_next     = idx_reg;
        cnt_next     = cnt_reg;
        result_next  = result_reg;
        valid_next   = valid_reg;
        overrun_next = overrun_reg;
        trial_code   = code_reg;
        decide       = 1'b0;
        bit_value    = cmp_s;
        complete     = 1'b0;
`ifdef THRESHOLD_SAR_MAJORITY_EN
        phase_next   = phase_reg;
        samp_next    = samp_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (start || cont) begin
                    state_next = SETTLE;
                    code_next  = MSB_CODE;
                    idx_next   = IDX_MSB;
                    cnt_next   = CNT_LOAD;
                end
            end
            SETTLE: begin
                if (cnt_reg == '0) begin
                    state_next = SAMPLE;
`ifdef THRESHOLD_SAR_MAJORITY_EN
                    phase_next = '0;
`endif
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            SAMPLE: begin
`ifdef THRESHOLD_SAR_MAJORITY_EN
                // Two earlier samples are held; the third arrives on the deciding cycle.
                if (phase_reg == 2'd2) begin
                    decide    = 1'b1;
                    bit_value = (samp_reg[1] & samp_reg[0]) | (samp_reg[1] & cmp_s)
                              | (samp_reg[0] & cmp_s);
                end else begin
                    phase_next = phase_reg + 2'd1;
                    samp_next  = {samp_reg[0], cmp_s};
                end
`else
                decide = 1'b1;
`endif
                if (decide) begin
                    trial_code[idx_reg] = bit_value;
                    if (idx_reg != '0) begin
                        trial_code[idx_reg - 1'b1] = 1'b1;
                        code_next  = trial_code;
                        idx_next   = idx_reg - 1'b1;
                        cnt_next   = CNT_LOAD;
                        state_next = SETTLE;
                    end else begin
                        complete    = 1'b1;
                        result_next = trial_code;
                        if (cont) begin
                            state_next = SETTLE;
                            code_next  = MSB_CODE;
                            idx_next   = IDX_MSB;
                            cnt_next   = CNT_LOAD;
                        end else begin
                            state_next = IDLE;
                            code_next  = trial_code;
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A completion wins over acceptance: valid stays high carrying the new result.
        if (complete) begin
            valid_next = 1'b1;
            if (valid_reg) begin
                overrun_next = result_ready ? 1'b0 : 1'b1;
            end
        end else if (valid_reg && result_ready) begin
            valid_next   = 1'b0;
            overrun_next = 1'b0;
        end
    end

    assign code_out     = code_reg;
    assign busy         = (state_reg != IDLE);
    assign result       = result_reg;
    assign result_valid = valid_reg;
    assign overrun      = overrun_reg;

endmodule

// File: tb/tb_threshold_sar_ctrl.sv
// Bench for threshold_sar_ctrl: comparator model driven by code_out, expected results queued per conversion.
module tb_threshold_sar_ctrl;

    localparam int CODE_W        = 3;
    localparam int SETTLE_CYCLES = 16;
    localparam int SYNC_STAGES   = 2;
`ifdef THRESHOLD_SAR_MAJORITY_EN
    localparam int CONV = CODE_W * (SETTLE_CYCLES + 3);
    localparam logic [CODE_W-1:0] GLITCH_RESULT = 3'd6;
`else
    localparam int CONV = CODE_W * (SETTLE_CYCLES + 1);
    localparam logic [CODE_W-1:0] GLITCH_RESULT = 3'd3;
`endif
    localparam int PER   = CONV / CODE_W;
    localparam int LIMIT = 4 * CONV;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              cont;
    logic              cmp_in;
    logic              result_ready;
    logic [CODE_W-1:0] code_out;
    logic [CODE_W-1:0] result;
    logic              busy;
    logic              result_valid;
    logic              overrun;

    int                cmp_mode;   // 0 = model, 1 = stuck high, 2 = stuck low
    int                model_n;
    logic              glitch;
    logic [CODE_W-1:0] exp_q[$];
    int                checks = 0;
    int                fails  = 0;

    threshold_sar_ctrl #(
        .CODE_W       (CODE_W),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .SYNC_STAGES  (SYNC_STAGES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cont        (cont),
        .cmp_in      (cmp_in),
        .code_out    (code_out),
        .busy        (busy),
        .result      (result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (glitch)             cmp_in = 1'b0;
        else if (cmp_mode == 1) cmp_in = 1'b1;
        else if (cmp_mode == 2) cmp_in = 1'b0;
        else                    cmp_in = (int'(code_out) <= model_n);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic accept();
        result_ready = 1'b1;
        step();
        result_ready = 1'b0;
    endtask

    task automatic wait_idle(inout int n);
        while (busy && n < LIMIT) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++; if (code_out !== '0) begin fails++; $display("FAIL reset_code_out got=%0d want=0", code_out); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (result !== '0) begin fails++; $display("FAIL reset_result got=%0d want=0", result); end
        checks++; if (result_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b want=0", result_valid); end
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL reset_overrun got=%b want=0", overrun); end
        rst = 1'b0;
        step();
        $display("reset: outputs code=%0d busy=%b result=%0d valid=%b overrun=%b", code_out, busy, result, result_valid, overrun);
    endtask

    task automatic test_convert_model();
        logic [CODE_W-1:0] trials[$];
        int                change_n[$];
        logic [CODE_W-1:0] last;
        logic [CODE_W-1:0] exp_r;
        logic              early_valid;
        int                n;
        cmp_mode = 0;
        model_n  = 5;
        exp_q.push_back(3'd5);
        pulse_start();
        trials.push_back(code_out);
        last        = code_out;
        early_valid = 1'b0;
        n           = 0;
        while (busy && n < LIMIT) begin
            step();
            n++;
            if (busy && result_valid) early_valid = 1'b1;
            if (busy && code_out !== last) begin
                trials.push_back(code_out);
                change_n.push_back(n);
                last = code_out;
            end
        end
        exp_r = exp_q.pop_front();
        $display("conv model5: result=%0d cycles=%0d trials=%0d", result, n, trials.size());
        checks++; if (n !== CONV) begin fails++; $display("FAIL model5_latency got=%0d want=%0d", n, CONV); end
        checks++; if (trials.size() != 3 || trials[0] !== 3'd4 || trials[1] !== 3'd6 || trials[2] !== 3'd5) begin
            fails++; $display("FAIL model5_trials got=%p want=4,6,5", trials); end
        checks++; if (change_n.size() != 2 || change_n[0] != PER || change_n[1] != 2 * PER) begin
            fails++; $display("FAIL model5_code_timing got=%p want=%0d,%0d", change_n, PER, 2 * PER); end
        checks++; if (early_valid !== 1'b0) begin fails++; $display("FAIL model5_early_valid got=1 want=0"); end
        checks++; if (result !== exp_r) begin fails++; $display("FAIL model5_result got=%0d want=%0d", result, exp_r); end
        checks++; if (result_valid !== 1'b1) begin fails++; $display("FAIL model5_valid got=%b want=1", result_valid); end
        step();
        step();
        checks++; if (code_out !== 3'd5) begin fails++; $display("FAIL model5_code_hold got=%0d want=5", code_out); end
        accept();
        checks++; if (result_valid !== 1'b0) begin fails++; $display("FAIL model5_accept got=%b want=0", result_valid); end
    endtask

    task automatic test_stuck();
        int                modes[2]  = '{1, 2};
        logic [CODE_W-1:0] expect_v[2] = '{3'd7, 3'd0};
        logic [CODE_W-1:0] exp_r;
        for (int k = 0; k < 2; k++) begin
            int n = 0;
            cmp_mode = modes[k];
            exp_q.push_back(expect_v[k]);
            pulse_start();
            wait_idle(n);
            exp_r = exp_q.pop_front();
            $display("conv stuck%0d: result=%0d cycles=%0d", k, result, n);
            checks++; if (n !== CONV) begin fails++; $display("FAIL stuck%0d_latency got=%0d want=%0d", k, n, CONV); end
            checks++; if (result !== exp_r || result_valid !== 1'b1) begin
                fails++; $display("FAIL stuck%0d_result got=%0d/v%b want=%0d/v1", k, result, result_valid, exp_r); end
            accept();
        end
    endtask

    task automatic test_back_to_back();
        logic [CODE_W-1:0] exp_r;
        int                n;
        cmp_mode = 0;
        model_n  = 3;
        exp_q.push_back(3'd3);
        cont = 1'b1;
        step();
        for (n = 1; n < CONV; n++) step();
        checks++; if (result_valid !== 1'b0) begin fails++; $display("FAIL b2b_pre_valid got=%b want=0", result_valid); end
        step();
        exp_r = exp_q.pop_front();
        $display("conv b2b first: result=%0d busy=%b overrun=%b", result, busy, overrun);
        checks++; if (result !== exp_r || result_valid !== 1'b1) begin
            fails++; $display("FAIL b2b_first got=%0d/v%b want=%0d/v1", result, result_valid, exp_r); end
        checks++; if (busy !== 1'b1 || overrun !== 1'b0) begin
            fails++; $display("FAIL b2b_first_flags got busy=%b ovr=%b want busy=1 ovr=0", busy, overrun); end
        exp_q.push_back(3'd3);
        for (n = 1; n < CONV; n++) step();
        checks++; if (overrun !== 1'b0) begin fails++; $display("FAIL b2b_pre_overrun got=%b want=0", overrun); end
        step();
        exp_r = exp_q.pop_front();
        $display("conv b2b second: result=%0d busy=%b overrun=%b", result, busy, overrun);
        checks++; if (overrun !== 1'b1 || result !== exp_r || busy !== 1'b1) begin
            fails++; $display("FAIL b2b_overrun got ovr=%b res=%0d busy=%b want ovr=1 res=%0d busy=1", overrun, result, busy, exp_r); end
        exp_q.push_back(3'd3);
        accept();
        cont = 1'b0;
        checks++; if (result_valid !== 1'b0 || overrun !== 1'b0) begin
            fails++; $display("FAIL b2b_accept got v=%b ovr=%b want v=0 ovr=0", result_valid, overrun); end
        n = 2 * CONV + 1;
        wait_idle(n);
        exp_r = exp_q.pop_front();
        $display("conv b2b third: result=%0d cycles=%0d", result, n);
        checks++; if (n !== 3 * CONV) begin fails++; $display("FAIL b2b_third_latency got=%0d want=%0d", n, 3 * CONV); end
        checks++; if (result !== exp_r || result_valid !== 1'b1 || overrun !== 1'b0) begin
            fails++; $display("FAIL b2b_third got=%0d/v%b/o%b want=%0d/v1/o0", result, result_valid, overrun, exp_r); end
        accept();
    endtask

    task automatic test_start_ignored();
        logic [CODE_W-1:0] exp_r;
        int                n = 0;
        cmp_mode = 0;
        model_n  = 6;
        exp_q.push_back(3'd6);
        pulse_start();
        while (busy && n < LIMIT) begin
            step();
            n++;
            start = (n == 19);
        end
        start = 1'b0;
        exp_r = exp_q.pop_front();
        $display("conv start_ignored: result=%0d cycles=%0d", result, n);
        checks++; if (n !== CONV) begin fails++; $display("FAIL ignore_latency got=%0d want=%0d", n, CONV); end
        checks++; if (result !== exp_r || result_valid !== 1'b1) begin
            fails++; $display("FAIL ignore_result got=%0d/v%b want=%0d/v1", result, result_valid, exp_r); end
        repeat (5) step();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL ignore_no_rerun got busy=%b want=0", busy); end
        accept();
    endtask

    task automatic test_reset_mid();
        logic [CODE_W-1:0] exp_r;
        int                n;
        cmp_mode = 0;
        model_n  = 5;
        pulse_start();
        for (n = 1; n < 30; n++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        $display("reset_mid: code=%0d busy=%b result=%0d valid=%b overrun=%b", code_out, busy, result, result_valid, overrun);
        checks++; if ({code_out, busy, result, result_valid, overrun} !== '0) begin
            fails++; $display("FAIL reset_mid_outputs got code=%0d busy=%b res=%0d v=%b o=%b want all 0",
                              code_out, busy, result, result_valid, overrun); end
        exp_q.push_back(3'd5);
        pulse_start();
        n = 0;
        wait_idle(n);
        exp_r = exp_q.pop_front();
        $display("conv after_reset: result=%0d cycles=%0d", result, n);
        checks++; if (n !== CONV || result !== exp_r || result_valid !== 1'b1) begin
            fails++; $display("FAIL reset_mid_reconvert got=%0d/%0d cycles want=%0d/%0d cycles", result, n, exp_r, CONV); end
        accept();
    endtask

    task automatic test_glitch();
        logic [CODE_W-1:0] exp_r;
        int                n = 0;
        cmp_mode = 0;
        model_n  = 6;
        exp_q.push_back(GLITCH_RESULT);
        pulse_start();
        while (busy && n < LIMIT) begin
            step();
            n++;
            glitch = (n == 14);
        end
        glitch = 1'b0;
        exp_r = exp_q.pop_front();
        $display("conv glitch: result=%0d cycles=%0d", result, n);
        checks++; if (n !== CONV) begin fails++; $display("FAIL glitch_latency got=%0d want=%0d", n, CONV); end
        checks++; if (result !== exp_r) begin fails++; $display("FAIL glitch_result got=%0d want=%0d", result, exp_r); end
        accept();
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        cont         = 1'b0;
        result_ready = 1'b0;
        glitch       = 1'b0;
        cmp_mode     = 2;
        model_n      = 0;
        test_reset();
        test_convert_model();
        test_stuck();
        test_back_to_back();
        test_start_ignored();
        test_reset_mid();
        test_glitch();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/threshold_sar_ctrl.md
# threshold_sar_ctrl

Digital successive-approximation controller for the programmable threshold voltage sensor. It drives the 3-bit threshold-select code into the threshold decoder, which steers the analog comparator's reference tap. It reads back the asynchronous comparator output and resolves, MSB first, the highest threshold code the sensed voltage exceeds. The result is presented on a valid/ready port for the tile's digital logic or output pins.

## Interface
Parameters:
- `CODE_W`, 3: threshold code width; matches decoder input width.
- `SETTLE_CYCLES`, 16: cycles the code is held before the comparator is sampled. Must be ≥ `SYNC_STAGES`+1; elaboration error otherwise.
- `SYNC_STAGES`, 2: flops in the comparator synchronizer.

Ports:
- `clk`  in  1  clock; sole clock domain.
- `rst`  in  1  reset: synchronous, active-high.
- `start`  in  1  level; sampled in IDLE to begin a conversion.
- `cont`  in  1  continuous mode: auto-restart after each conversion while high.
- `cmp_in`  in  1  comparator output, asynchronous; 1 = input above current threshold.
- `code_out`  out  CODE_W  threshold code to decoder.
- `busy`  out  1  conversion in progress.
- `result`  out  CODE_W  last completed conversion.
- `result_valid`  out  1  result available.
- `result_ready`  in  1  consumer accepts result.
- `overrun`  out  1  sticky: a result was overwritten before being accepted.

## Operation
- Reset values: `code_out`=0, `busy`=0, `result`=0, `result_valid`=0, `overrun`=0, FSM=IDLE, synchronizer flops=0.
- `cmp_in` passes through a `SYNC_STAGES`-flop synchronizer. Only the synchronized value `cmp_s` is used.
- FSM states: IDLE, SETTLE, SAMPLE.
- IDLE: `busy`=0. `code_out` holds the last `result`, so the threshold rests at the measured level. On `start` or `cont` high:
  - bit index i = CODE_W-1;
  - `code_out` = 1<<i (all other bits 0);
  - settle counter = `SETTLE_CYCLES`-1;
  - go to SETTLE; `busy`=1.
- SETTLE: decrement the counter. At 0, go to SAMPLE.
- SAMPLE:
  - bit i of `code_out` keeps its trial 1 if `cmp_s`=1, else it is cleared.
  - If i>0: set bit i-1, decrement i, reload the counter, go to SETTLE.
  - If i=0: load `result` with the final code. `code_out` keeps that final code.
- Completion:
  - `result_valid` is set.
  - If `result_valid` was already 1 and `result_ready` is 0 in the completion cycle, `overrun` is set. The new result overwrites the old one.
  - Then go to IDLE. If `cont`=1, go straight to SETTLE for a new conversion instead; `busy` stays 1.
- Handshake: `result_valid` clears on any cycle with `result_valid` && `result_ready` that is not a completion cycle.
  - Completion and acceptance in the same cycle: `result_valid` stays 1 with the new result, and `overrun` is not set.
  - `overrun` clears on an accepted handshake or on `rst`.
- `start` while busy: ignored. Deasserting `cont` mid-conversion finishes the current conversion, then goes to IDLE.
- `rst` mid-conversion: all state returns to reset values on that edge, and no partial result is published.

## Timing
- Conversion time: `CODE_W`×(`SETTLE_CYCLES`+1) cycles from the edge that samples `start` to the edge that sets `result_valid`. Defaults: 51 cycles.
- `code_out` changes only on the IDLE→SETTLE edge and on SAMPLE edges. It is never glitched mid-settle.
- In continuous mode, back-to-back conversions have no idle cycle.
- `cmp_in` to `cmp_s` latency: `SYNC_STAGES` cycles. The settle window covers this.

## Configuration
- `THRESHOLD_SAR_MAJORITY_EN` defined: SAMPLE lasts 3 cycles. The bit decision is the majority of `cmp_s` over those 3 cycles. Conversion time becomes `CODE_W`×(`SETTLE_CYCLES`+3) (57 with defaults).
- `THRESHOLD_SAR_MAJORITY_EN` not defined: single-sample decision, timing as above.

## Test plan
- Comparator model `cmp_in = (code_out <= 5)`, pulse `start` → `busy` for 51 cycles. `code_out` trials are 4, then 6, then 5. `result`=5, `result_valid`=1 at cycle 51, then `code_out` holds 5.
- `cmp_in` stuck at 1 → `result`=7. `cmp_in` stuck at 0 → `result`=0. Both at cycle 51.
- `cont`=1, `result_ready`=0, model N=3 → first result 3. The second completion sets `overrun`=1 with `result`=3. Assert `result_ready` → `result_valid`=0 and `overrun`=0 next cycle.
- Pulse `start` again at cycle 20 of a conversion → ignored. Completion still at cycle 51 with one result.
- Assert `rst` at cycle 30 of a conversion → next cycle every output is 0. A new `start` converts normally.
- With `THRESHOLD_SAR_MAJORITY_EN`, N=6, inject a 1-cycle `cmp_in` glitch to 0 in the MSB SAMPLE window → `result`=6 at cycle 57. Without the macro, the same glitch aligned to the sample cycle yields `result`=3.
